// File: rtl/elastic_pipeline_register.sv
// Elastic pipeline stage register: valid/ready flow control, hazard flush and an
// optional skid entry so that in_ready comes straight from a register.
module elastic_pipeline_register #(
  parameter int PAYLOAD_WIDTH  = 160,
  parameter bit SKID_ENABLE    = 1'b1,
  parameter bit CLEAR_ON_FLUSH = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PAYLOAD_WIDTH-1:0] in_payload,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PAYLOAD_WIDTH-1:0] out_payload,
  output logic [1:0]               occupancy
);

  // Handshake: a transfer happens on a posedge where valid and ready are both high;
  // in_ready never depends on in_valid, and out_payload stays put while out_valid & !out_ready.

  // The state encoding equals the number of held entries, so occupancy doubles as the debug view.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                   state, state_next;
  logic [PAYLOAD_WIDTH-1:0] main_q, main_d;
  logic [PAYLOAD_WIDTH-1:0] skid_q, skid_d;
  logic                     accept, consume;

  assign out_valid   = (state != EMPTY);
  assign out_payload = main_q;
  assign occupancy   = state;

  always_comb begin
    if (SKID_ENABLE) begin
      in_ready = (state != FULL) && !reset;
    end else begin
      in_ready = ((state == EMPTY) || out_ready) && !reset;
    end
  end

  assign accept  = in_valid && in_ready;
  assign consume = out_valid && out_ready;

  always_comb begin
    state_next = state;
    main_d     = main_q;
    skid_d     = skid_q;
    if (reset) begin
      state_next = EMPTY;
      main_d     = '0;
      skid_d     = '0;
    end else if (flush) begin
      state_next = EMPTY;
      if (CLEAR_ON_FLUSH) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_d     = in_payload;
            state_next = ONE;
          end
        end
        ONE: begin
          if (accept && consume) begin
            main_d = in_payload;
          end else if (accept) begin
            // Only reachable with the skid entry: without it, accepting in ONE implies a consume.
            skid_d     = in_payload;
            state_next = FULL;
          end else if (consume) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (consume) begin
            main_d     = skid_q;
            state_next = ONE;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    state  <= state_next;
    main_q <= main_d;
    skid_q <= skid_d;
  end

endmodule
